// File: rtl/e0_sequencer.sv
`default_nettype none
// e0_sequencer: steps an E0 keystream core through clear/load/mix/clear/reload and then streams keystream bits.
// Revision 1.0 - initial release.
module e0_sequencer #(
  parameter int LOAD_BITS  = 128,
  parameter int MIX_CYCLES = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LOAD_BITS-1:0] key_in,
  input  logic [15:0]          ks_len,
  output logic                 busy,
  output logic                 done,
  output logic                 core_clr,
  output logic                 core_load,
  output logic                 core_din,
  output logic                 core_en,
  input  logic                 core_z,
  output logic                 ks_bit,
  output logic                 ks_valid,
  input  logic                 ks_ready
);

  localparam int PW = (MIX_CYCLES > 1) ? $clog2(MIX_CYCLES) : 1;
  localparam logic [PW-1:0] LOAD_LAST     = PW'(LOAD_BITS - 1);
  localparam logic [PW-1:0] MIX_LAST      = PW'(MIX_CYCLES - 1);
  localparam logic [PW-1:0] MIX_FIRST_CAP = PW'(MIX_CYCLES - LOAD_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR1   = 3'd1,
    LOAD1  = 3'd2,
    MIX    = 3'd3,
    CLR2   = 3'd4,
    LOAD2  = 3'd5,
    STREAM = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [LOAD_BITS-1:0] key_q, key_d;
  logic [LOAD_BITS-1:0] cap_q, cap_d;
  logic [15:0]          len_q, len_d;
  logic [15:0]          xfer_q, xfer_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      key_q   <= '0;
      cap_q   <= '0;
      len_q   <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      key_q   <= key_d;
      cap_q   <= cap_d;
      len_q   <= len_d;
      xfer_q  <= xfer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    cap_d     = cap_q;
    len_d     = len_q;
    xfer_d    = xfer_q;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    core_clr  = 1'b0;
    core_load = 1'b0;
    core_din  = 1'b0;
    core_en   = 1'b0;
    ks_valid  = 1'b0;
    ks_bit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          len_d   = ks_len;
          xfer_d  = '0;
          state_d = CLR1;
        end
      end
      CLR1: begin
        core_clr = 1'b1;
        state_d  = LOAD1;
      end
      LOAD1: begin
        // Key is consumed LSB first by shifting the latched copy down.
        core_load = 1'b1;
        core_din  = key_q[0];
        key_d     = key_q >> 1;
        if (phase_q == LOAD_LAST) state_d = MIX;
      end
      MIX: begin
        core_en = 1'b1;
        if (phase_q >= MIX_FIRST_CAP) cap_d = {core_z, cap_q[LOAD_BITS-1:1]};
        if (phase_q == MIX_LAST) state_d = CLR2;
      end
      CLR2: begin
        core_clr = 1'b1;
        state_d  = LOAD2;
      end
      LOAD2: begin
        core_load = 1'b1;
        core_din  = cap_q[0];
        cap_d     = cap_q >> 1;
        xfer_d    = '0;
        if (phase_q == LOAD_LAST) state_d = (len_q == 16'd0) ? DONE : STREAM;
      end
      STREAM: begin
        ks_valid = 1'b1;
        ks_bit   = core_z;
        core_en  = ks_ready;
        if (ks_ready) begin
          xfer_d = xfer_q + 16'd1;
          if (xfer_q == len_q - 16'd1) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    phase_d = (state_d != state_q) ? '0 : phase_q + PW'(1);
  end

endmodule
`default_nettype wire

// File: tb/tb_e0_sequencer.sv
`default_nettype none
// tb_e0_sequencer: cycle-level reference model of the E0 init/stream schedule plus directed scenarios.
// Revision 1.0 - initial release.
module tb_e0_sequencer;
  localparam int LB = 128;
  localparam int MC = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LB-1:0] key_in = '0;
  logic [15:0]   ks_len = '0;
  logic          ks_ready = 1'b1;
  logic          busy, done, core_clr, core_load, core_din, core_en, core_z, ks_bit, ks_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int adv   = 0;
  int zmode = 0;
  bit rdy_mode = 1'b0;
  bit chk_en   = 1'b0;

  e0_sequencer #(.LOAD_BITS(LB), .MIX_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .ks_len(ks_len),
    .busy(busy), .done(done), .core_clr(core_clr), .core_load(core_load),
    .core_din(core_din), .core_en(core_en), .core_z(core_z),
    .ks_bit(ks_bit), .ks_valid(ks_valid), .ks_ready(ks_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keystream bit as a function of how many steps the core has taken since its last clear.
  function automatic logic zpat(input int n, input int m);
    logic [31:0] x;
    if (m == 0) return 1'b0;
    x = (32'(n) * 32'h2545F491) ^ 32'h5A5A1234;
    return x[13] ^ x[22] ^ x[3];
  endfunction

  // Stand-in for the E0 core: a step counter cleared by core_clr and advanced by core_en.
  always @(posedge clk) begin
    if (core_clr) adv <= 0;
    else if (core_en) adv <= adv + 1;
  end
  assign core_z = zpat(adv, zmode);

  // Reference schedule, indexed by time since the accepted start.
  bit            m_act = 1'b0;
  int            m_T = 0, m_L = 0, m_x = 0;
  logic [LB-1:0] m_K = '0;
  int            f_valid = -1, d_cyc = -1, din_n = 0, din_c = -1, nx = 0;

  always @(negedge clk) begin
    logic [7:0] exp_v, act_v;
    int t;
    exp_v = 8'd0;
    if (m_act) begin
      t = cyc - m_T;
      exp_v[7] = 1'b1;
      if (t == 1 || t == 2 + LB + MC) exp_v[5] = 1'b1;
      else if (t <= 1 + LB) begin
        exp_v[4] = 1'b1;
        exp_v[3] = m_K[t-2];
      end else if (t <= 1 + LB + MC) exp_v[2] = 1'b1;
      else if (t <= 2 + 2*LB + MC) begin
        exp_v[4] = 1'b1;
        exp_v[3] = zpat((MC - LB) + (t - (3 + LB + MC)), zmode);
      end else if (m_x < m_L) begin
        exp_v[1] = 1'b1;
        exp_v[0] = zpat(m_x, zmode);
        exp_v[2] = ks_ready;
      end else exp_v[6] = 1'b1;
    end
    act_v = {busy, done, core_clr, core_load, core_din, core_en, ks_valid, ks_bit};
    if (chk_en) begin
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL cycle_cmp cyc=%0d t=%0d got=%b want=%b (busy,done,clr,load,din,en,valid,bit)",
                 cyc, cyc - m_T, act_v, exp_v);
      end
    end
    if (ks_valid && f_valid < 0) f_valid = cyc;
    if (done) d_cyc = cyc;
    if (core_din) begin din_n++; din_c = cyc; end
    if (ks_valid && ks_ready) nx++;
    if (m_act && exp_v[1] && ks_ready) m_x++;
    if (rst) m_act = 1'b0;
    else if (m_act && exp_v[6]) m_act = 1'b0;
    else if (!m_act && start) begin
      m_act = 1'b1; m_T = cyc; m_L = int'(ks_len); m_K = key_in; m_x = 0;
      f_valid = -1; d_cyc = -1; din_n = 0; din_c = -1; nx = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ks_ready = rdy_mode ? ((cyc % 3) == 0) : 1'b1;
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic go(input logic [LB-1:0] k, input int len, output int T);
    key_in = k;
    ks_len = len[15:0];
    start  = 1'b1;
    T      = cyc;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (d_cyc < 0 && n < 800) begin tick(); n++; end
    if (d_cyc < 0) begin
      total++; bad++;
      $display("FAIL %s_timeout got=no_done want=done", name);
    end
  endtask

  initial begin
    int T, c0;
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_outputs", int'({busy, done, core_clr, core_load, core_din, core_en, ks_valid, ks_bit}), 0);

    // Nominal: single key bit set, silent core, 8 bits at full rate.
    zmode = 0;
    go(128'h1, 8, T);
    wait_done("nominal");
    check("nom_first_valid", f_valid - T, 459);
    check("nom_done_at", d_cyc - T, 467);
    check("nom_din_ones", din_n, 1);
    check("nom_din_at", din_c - T, 2);
    check("nom_xfers", nx, 8);
    check("nom_busy_low", int'(busy), 0);
    check("nom_idle_at", cyc - T, 468);

    // Capture path with a non-trivial core pattern.
    zmode = 1;
    go(128'hDEADBEEF_01234567_89ABCDEF_F00DCAFE, 20, T);
    wait_done("capture");
    check("cap_done_at", d_cyc - T, 479);
    check("cap_xfers", nx, 20);

    // Backpressure: ready high every third cycle.
    rdy_mode = 1'b1;
    tick();
    go(128'h0F0F_0000_1234_5678_9ABC_DEF0_5555_AAAA, 10, T);
    wait_done("backpressure");
    c0 = T + 459;
    while (c0 % 3 != 0) c0++;
    check("bp_xfers", nx, 10);
    check("bp_done_at", d_cyc - T, c0 + 27 + 1 - T);
    rdy_mode = 1'b0;
    tick();

    // Zero-length session.
    go(128'hFFFF, 0, T);
    wait_done("len0");
    check("len0_done_at", d_cyc - T, 459);
    check("len0_no_valid", f_valid, -1);

    // Start during MIX is ignored.
    go(128'h1234_5678, 4, T);
    while (cyc < T + 150) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("mix_start");
    check("mixstart_done_at", d_cyc - T, 463);
    check("mixstart_xfers", nx, 4);

    // Reset mid-session, then a fresh session.
    go(128'hA5A5, 5, T);
    while (cyc < T + 200) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_outputs", int'({busy, done, core_clr, core_load, core_din, core_en, ks_valid, ks_bit}), 0);
    go(128'h5A5A, 3, T);
    wait_done("after_rst");
    check("after_rst_first_valid", f_valid - T, 459);
    check("after_rst_done_at", d_cyc - T, 462);
    check("after_rst_xfers", nx, 3);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
